// File: rtl/seq_pkg.sv
// Shared types and constants for the programmable sequence detector.
package seq_pkg;
  localparam int SYM_W       = 3;
  localparam int DEF_MAX_LEN = 8;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY,
    ARMED
  } state_t;
endpackage

// File: rtl/seq_match_window.sv
// Symbol history window plus a length-masked comparator against the pattern.
// The hit is evaluated on the window as it will look after the incoming
// symbol is shifted in. The controller registers the hit on that same edge.
module seq_match_window #(
  parameter int MAX_LEN = seq_pkg::DEF_MAX_LEN,
  parameter int SYM_W   = seq_pkg::SYM_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            shift,
  input  logic [SYM_W-1:0]                data,
  input  logic [MAX_LEN-1:0][SYM_W-1:0]   pattern,
  input  logic [LEN_W-1:0]                len,
  output logic                            hit
);
  localparam int IDX_W = $clog2(MAX_LEN);

  // win[0] is the newest symbol. pattern[0] is the oldest pattern symbol.
  logic [MAX_LEN-1:0][SYM_W-1:0] hist, win;
  logic [LEN_W-1:0]              hist_n, hist_n_nxt;
  logic [IDX_W-1:0]              k;
  logic                          eq;

  assign win        = {hist[MAX_LEN-2:0], data};
  assign hist_n_nxt = (hist_n == LEN_W'(MAX_LEN)) ? hist_n : hist_n + LEN_W'(1);

  // Compare the newest len symbols against pattern, oldest-first alignment.
  always_comb begin
    eq = 1'b1;
    k  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      k = IDX_W'(len - LEN_W'(i) - LEN_W'(1));
      if (LEN_W'(i) < len && pattern[k] != win[i]) eq = 1'b0;
    end
  end

  assign hit = shift && (len != '0) && (hist_n_nxt >= len) && eq;

  // History shift register and valid-depth counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist   <= '0;
      hist_n <= '0;
    end else if (shift) begin
      hist   <= win;
      hist_n <= hist_n_nxt;
    end
  end
endmodule

// File: rtl/sequence_detect_ctrl.sv
// Programmable sequence detector: pattern load over ready/valid, arm/disarm,
// overlapping match counting with an optional auto-stop limit.
module sequence_detect_ctrl #(
  parameter int MAX_LEN = seq_pkg::DEF_MAX_LEN,
  parameter int SYM_W   = seq_pkg::SYM_W,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic             cfg_last,
  input  logic [CNT_W-1:0] match_limit,
  input  logic             arm,
  input  logic             disarm,
  input  logic             data_valid,
  input  logic [SYM_W-1:0] data,
  output logic             sequence_found,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             cfg_err,
  output logic             armed
);
  import seq_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);

  state_t                        state, state_nxt;
  logic [LEN_W-1:0]              len, len_nxt;
  logic [MAX_LEN-1:0][SYM_W-1:0] pat, pat_nxt;
  logic [CNT_W-1:0]              limit, lim_nxt, cnt_nxt, cnt_inc;
  logic                          err_nxt, found_nxt, done_nxt;
  logic                          cfg_xfer, clear, shift, hit;

  assign cfg_ready = (state != ARMED);
  assign armed     = (state == ARMED);
  assign cfg_xfer  = cfg_valid && cfg_ready;
  // A config transfer in READY takes precedence over arm.
  assign clear     = arm && ((state == ARMED) || (state == READY && !cfg_valid));
  assign shift     = (state == ARMED) && !arm && data_valid;
  assign cnt_inc   = (&match_count) ? match_count : match_count + CNT_W'(1);

  seq_match_window #(.MAX_LEN(MAX_LEN), .SYM_W(SYM_W), .LEN_W(LEN_W)) u_win (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .shift   (shift),
    .data    (data),
    .pattern (pat),
    .len     (len),
    .hit     (hit)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    pat_nxt   = pat;
    err_nxt   = cfg_err;
    cnt_nxt   = match_count;
    lim_nxt   = limit;
    found_nxt = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE, READY: begin
        if (cfg_xfer) begin
          pat_nxt[0] = cfg_sym;
          len_nxt    = LEN_W'(1);
          err_nxt    = 1'b0;
          state_nxt  = cfg_last ? READY : LOAD;
        end else if (state == READY && arm) begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
          lim_nxt   = match_limit;
        end
      end
      LOAD: begin
        if (cfg_xfer) begin
          if (len < LEN_W'(MAX_LEN)) begin
            pat_nxt[len[IDX_W-1:0]] = cfg_sym;
            len_nxt = len + LEN_W'(1);
          end else begin
            err_nxt = 1'b1;
          end
          if (cfg_last) state_nxt = READY;
        end
      end
      ARMED: begin
        if (arm) begin
          cnt_nxt = '0;
          lim_nxt = match_limit;
        end else begin
          if (hit) begin
            found_nxt = 1'b1;
            cnt_nxt   = cnt_inc;
            if (limit != '0 && cnt_inc == limit) begin
              done_nxt  = 1'b1;
              state_nxt = READY;
            end
          end
          if (disarm) state_nxt = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      len            <= '0;
      pat            <= '0;
      cfg_err        <= 1'b0;
      match_count    <= '0;
      limit          <= '0;
      sequence_found <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      len            <= len_nxt;
      pat            <= pat_nxt;
      cfg_err        <= err_nxt;
      match_count    <= cnt_nxt;
      limit          <= lim_nxt;
      sequence_found <= found_nxt;
      done           <= done_nxt;
    end
  end
endmodule
